// File: rtl/shift_register_pkg.sv
// -----------------------------------------------------------------------------
// shift_register_pkg
//   Constants and small helpers shared by the UART receive and transmit paths.
//
//   OVERSAMPLE       : oversample ticks per serial bit
//   MID_SAMPLE       : oversample count at which a bit is sampled (mid-bit)
//   DATA_BITS        : data bits per character
//   TICK_DIV_DEFAULT : system clocks per oversample tick (100 MHz / (9600*16))
// -----------------------------------------------------------------------------
package shift_register_pkg;

    localparam int unsigned OVERSAMPLE       = 16;
    localparam int unsigned DATA_BITS        = 8;
    localparam int unsigned TICK_DIV_DEFAULT = 651;

    // Counter widths derived from the constants above.
    localparam int unsigned OS_W      = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS + 1);

    // The externally visible oversample count is one bit wider than needed;
    // the extra MSB is always zero.
    localparam int unsigned COUNT_W   = OS_W + 1;

    typedef logic [OS_W-1:0]      os_cnt_t;
    typedef logic [BIT_CNT_W-1:0] bit_cnt_t;
    typedef logic [DATA_BITS-1:0] data_t;

    localparam os_cnt_t  MID_SAMPLE = os_cnt_t'(7);
    localparam bit_cnt_t BITS_FULL  = bit_cnt_t'(DATA_BITS);
    localparam bit_cnt_t BITS_LAST  = bit_cnt_t'(DATA_BITS - 1);

    // LSB-first assembly: the newest bit enters at the MSB, so after
    // DATA_BITS shifts the first bit received sits in bit 0.
    function automatic data_t shift_lsb_first(input data_t cur, input logic bit_in);
        return {bit_in, cur[DATA_BITS-1:1]};
    endfunction

endpackage : shift_register_pkg

// File: rtl/shift_register_if.sv
// -----------------------------------------------------------------------------
// shift_register_if
//   Bundle between the RX control FSM (master) and the RX bit sampler /
//   deserializer (slave).
//
//   data_in  : serial RX line, already synchronized          (master -> slave)
//   sel      : shift enable, 1 while data bits are received  (master -> slave)
//   baud_clk : one-clk oversample tick                        (slave -> master)
//   shift_in : one-clk strobe when a bit is shifted in        (slave -> master)
//   done     : one-clk pulse when the last data bit lands     (slave -> master)
//   data_out : assembled byte, LSB first                      (slave -> master)
//   count    : oversample position inside the current bit     (slave -> master)
//   Count    : number of data bits captured, 0..DATA_BITS     (slave -> master)
// -----------------------------------------------------------------------------
interface shift_register_if import shift_register_pkg::*; ();

    logic                data_in;
    logic                sel;
    logic                baud_clk;
    logic                shift_in;
    logic                done;
    data_t               data_out;
    logic [COUNT_W-1:0]  count;
    bit_cnt_t            Count;

    modport master (
        output data_in,
        output sel,
        input  baud_clk,
        input  shift_in,
        input  done,
        input  data_out,
        input  count,
        input  Count
    );

    modport slave (
        input  data_in,
        input  sel,
        output baud_clk,
        output shift_in,
        output done,
        output data_out,
        output count,
        output Count
    );

endinterface : shift_register_if

// File: rtl/shift_register_baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
//   Free-running divider that produces a one-clk oversample tick every
//   TICK_DIV system clocks. Shared between the UART RX and TX paths.
//
//   TICK_DIV : system clocks per tick, must be >= 2
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-low reset
//   tick     : registered tick, high for the single clk after the divider
//              wraps; the first tick appears TICK_DIV clocks after reset
// -----------------------------------------------------------------------------
module baud_tick_gen import shift_register_pkg::*; #(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);

    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_r;
    logic             tick_r;
    logic             wrap_s;

    // Divider is on its final count this cycle and wraps at the next edge.
    always_comb begin
        wrap_s = 1'b0;
        if (div_r == DIV_LAST) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
    end

    // Divider counter and registered tick (tick lands in the wrap cycle).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_r  <= DIV_ZERO;
            tick_r <= 1'b0;
        end else if (wrap_s) begin
            div_r  <= DIV_ZERO;
            tick_r <= 1'b1;
        end else begin
            div_r  <= div_r + DIV_ONE;
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule : baud_tick_gen

// File: rtl/shift_register.sv
// -----------------------------------------------------------------------------
// shift_register
//   UART RX bit sampler and deserializer. Generates the 16x oversample tick,
//   and while sel is high samples the line at mid-bit, shifting DATA_BITS bits
//   LSB-first into data_out. done pulses with the final shift.
//
//   TICK_DIV : system clocks per oversample tick (>= 2)
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-low reset
//   bus      : shift_register_if.slave (data_in, sel in; baud_clk, shift_in,
//              done, data_out, count, Count out) -- all outputs registered
//
//   Alignment: count = 0 is the first tick on which sel is seen high, so the
//   first sample happens on the 8th tick and the last on the 120th.
// -----------------------------------------------------------------------------
module shift_register import shift_register_pkg::*; #(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    shift_register_if.slave bus
);

    logic     baud_clk_s;
    logic     sample_s;
    logic     last_s;

    os_cnt_t  os_cnt_r;
    bit_cnt_t bit_cnt_r;
    data_t    data_r;
    logic     shift_in_r;
    logic     done_r;

    baud_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_baud_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (baud_clk_s)
    );

    // Sample decision: an enabled tick at mid-bit while the byte has room.
    // A sel change coincident with a tick takes effect for that tick.
    always_comb begin
        sample_s = 1'b0;
        last_s   = 1'b0;
        if (bus.sel && baud_clk_s && (os_cnt_r == MID_SAMPLE) && (bit_cnt_r < BITS_FULL)) begin
            sample_s = 1'b1;
            last_s   = (bit_cnt_r == BITS_LAST);
        end else begin
            sample_s = 1'b0;
            last_s   = 1'b0;
        end
    end

    // Oversample/bit counters, shift register and strobes. Dropping sel
    // clears the counters (aborting any partial byte) but keeps data_r.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            os_cnt_r   <= os_cnt_t'(0);
            bit_cnt_r  <= bit_cnt_t'(0);
            data_r     <= data_t'(0);
            shift_in_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            shift_in_r <= sample_s;
            done_r     <= last_s;
            if (!bus.sel) begin
                os_cnt_r  <= os_cnt_t'(0);
                bit_cnt_r <= bit_cnt_t'(0);
            end else if (baud_clk_s) begin
                // Natural 4-bit wrap gives 15 -> 0.
                os_cnt_r <= os_cnt_r + os_cnt_t'(1);
                if (sample_s) begin
                    data_r    <= shift_lsb_first(data_r, bus.data_in);
                    bit_cnt_r <= bit_cnt_r + bit_cnt_t'(1);
                end else begin
                    data_r    <= data_r;
                    bit_cnt_r <= bit_cnt_r;
                end
            end else begin
                os_cnt_r  <= os_cnt_r;
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    assign bus.baud_clk = baud_clk_s;
    assign bus.shift_in = shift_in_r;
    assign bus.done     = done_r;
    assign bus.data_out = data_r;
    assign bus.count    = {1'b0, os_cnt_r};
    assign bus.Count    = bit_cnt_r;

endmodule : shift_register

// File: tb/tb_shift_register.sv
// -----------------------------------------------------------------------------
// tb_shift_register
//   Self-checking bench for shift_register with TICK_DIV = 4. A reference
//   model tracks clocks since reset, ticks seen since sel rose and the history
//   of sampled bits, and a negedge process compares every output each cycle.
//   Directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_shift_register;

    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = 16 * TICK_DIV;

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    logic sel     = 1'b0;
    logic data_in = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int n_baud  = 0;
    int n_shift = 0;
    int n_done  = 0;

    shift_register_if bus ();
    assign bus.sel     = sel;
    assign bus.data_in = data_in;

    shift_register #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int   m_cyc   = 0;   // clock edges since reset release
    int   m_ticks = 0;   // ticks seen with sel continuously high
    logic m_shift = 1'b0;
    logic m_done  = 1'b0;
    logic hist[$];       // every bit sampled since reset, oldest first
    logic exp_baud;

    always_comb exp_baud = (m_cyc != 0) && ((m_cyc % TICK_DIV) == 0);

    // Model update: a tick index k (since sel rose) with k%16==7 samples a bit
    // for the first eight such indices.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cyc   <= 0;
            m_ticks <= 0;
            m_shift <= 1'b0;
            m_done  <= 1'b0;
            hist.delete();
        end else begin
            m_cyc   <= m_cyc + 1;
            m_shift <= 1'b0;
            m_done  <= 1'b0;
            if (!sel) begin
                m_ticks <= 0;
            end else if (exp_baud) begin
                m_ticks <= m_ticks + 1;
                if (((m_ticks % 16) == 7) && (m_ticks < 7 + 16 * 8)) begin
                    hist.push_back(data_in);
                    m_shift <= 1'b1;
                    m_done  <= (m_ticks == 7 + 16 * 7);
                end
            end
        end
    end

    function automatic int exp_bits(input int n);
        int b;
        if (n < 8) b = 0;
        else       b = (n - 8) / 16 + 1;
        if (b > 8) b = 8;
        return b;
    endfunction

    // data_out is the last eight sampled bits, newest in bit 7.
    function automatic logic [7:0] exp_data();
        logic [7:0] d = 8'h00;
        for (int j = 0; j < 8; j++) begin
            if (hist.size() > j) d[7 - j] = hist[hist.size() - 1 - j];
        end
        return d;
    endfunction

    // Per-cycle compare against the model plus pulse counters.
    always @(negedge clk) begin
        chk("baud_clk", 32'(bus.baud_clk), 32'(exp_baud));
        chk("shift_in", 32'(bus.shift_in), 32'(m_shift));
        chk("done",     32'(bus.done),     32'(m_done));
        chk("data_out", 32'(bus.data_out), 32'(exp_data()));
        chk("count",    32'(bus.count),    32'(m_ticks % 16));
        chk("Count",    32'(bus.Count),    32'(exp_bits(m_ticks)));
        if (bus.shift_in) chk("count_after_sample", 32'(bus.count), 32'd8);
        if (bus.baud_clk) n_baud++;
        if (bus.shift_in) n_shift++;
        if (bus.done)     n_done++;
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Advance until the current cycle carries a tick, so raising sel now makes
    // the next edge tick index 0.
    task automatic align_tick();
        int guard = 0;
        while (!exp_baud && guard < 2 * TICK_DIV) begin
            step(1);
            guard++;
        end
        chk("align_tick_found", 32'(exp_baud), 32'd1);
    endtask

    // Send nbits of b LSB first, 16 ticks each; optional glitches of the
    // opposite level placed on tick edges away from the mid-bit sample.
    task automatic send_bits(input logic [7:0] b, input int nbits, input bit glitch);
        logic v;
        align_tick();
        sel = 1'b1;
        for (int k = 0; k < nbits; k++) begin
            v       = b[k];
            data_in = v;
            if (glitch) begin
                step(2 * TICK_DIV);      data_in = ~v;
                step(2);                 data_in = v;
                step(10 * TICK_DIV - 2); data_in = ~v;
                step(TICK_DIV);          data_in = v;
                step(3 * TICK_DIV);
            end else begin
                step(BIT_CLKS);
            end
        end
    endtask

    initial begin
        reset = 1'b0; sel = 1'b0; data_in = 1'b0;

        // Reset state
        #50;
        chk("rst_baud_clk", 32'(bus.baud_clk), 32'd0);
        chk("rst_shift_in", 32'(bus.shift_in), 32'd0);
        chk("rst_done",     32'(bus.done),     32'd0);
        chk("rst_data_out", 32'(bus.data_out), 32'h00);
        chk("rst_count",    32'(bus.count),    32'd0);
        chk("rst_Count",    32'(bus.Count),    32'd0);
        #50;
        @(posedge clk); #2;
        reset = 1'b1;

        // Idle: ticks every 4 clks, counters stay 0
        n_baud = 0; n_shift = 0; n_done = 0;
        step(41);
        chk("idle_baud_pulses", 32'(n_baud),    32'd10);
        chk("idle_done",        32'(n_done),    32'd0);
        chk("idle_count",       32'(bus.count), 32'd0);
        chk("idle_Count",       32'(bus.Count), 32'd0);

        // Byte 1,0,1,0,1,1,0,1 -> B5
        n_shift = 0; n_done = 0;
        send_bits(8'hB5, 8, 1'b0);
        chk("b5_data",   32'(bus.data_out), 32'hB5);
        chk("b5_model",  32'(exp_data()),   32'hB5);
        chk("b5_shifts", 32'(n_shift),      32'd8);
        chk("b5_done",   32'(n_done),       32'd1);
        chk("b5_Count",  32'(bus.Count),    32'd8);
        sel = 1'b0; step(2);

        // Byte 1,1,0,1,0,1,1,0 -> 6B, then two extra bit times with no shifts
        n_shift = 0; n_done = 0;
        send_bits(8'h6B, 8, 1'b0);
        chk("6b_data", 32'(bus.data_out), 32'h6B);
        chk("6b_done", 32'(n_done),       32'd1);
        n_shift = 0; n_done = 0;
        repeat (2 * BIT_CLKS) begin
            data_in = 1'($urandom_range(0, 1));
            step(1);
        end
        chk("hold_shifts", 32'(n_shift),      32'd0);
        chk("hold_done",   32'(n_done),       32'd0);
        chk("hold_Count",  32'(bus.Count),    32'd8);
        chk("hold_data",   32'(bus.data_out), 32'h6B);
        sel = 1'b0; step(2);

        // Abort after 3 bits (1,0,1): 6B -> B5 -> 5A -> AD
        n_done = 0;
        send_bits(8'h05, 3, 1'b0);
        chk("abort_Count_before", 32'(bus.Count), 32'd3);
        sel = 1'b0; step(1);
        chk("abort_count", 32'(bus.count),    32'd0);
        chk("abort_Count", 32'(bus.Count),    32'd0);
        chk("abort_done",  32'(n_done),       32'd0);
        chk("abort_data",  32'(bus.data_out), 32'hAD);
        step(3);
        n_done = 0;
        send_bits(8'hFF, 8, 1'b0);
        chk("ff_data", 32'(bus.data_out), 32'hFF);
        chk("ff_done", 32'(n_done),       32'd1);
        sel = 1'b0; step(2);

        // Reset asserted after 5 bits: outputs clear before the next edge
        n_done = 0;
        send_bits(8'h1F, 5, 1'b0);
        chk("mid_Count_before", 32'(bus.Count), 32'd5);
        reset = 1'b0;
        #1;
        chk("mid_rst_baud_clk", 32'(bus.baud_clk), 32'd0);
        chk("mid_rst_shift_in", 32'(bus.shift_in), 32'd0);
        chk("mid_rst_done",     32'(bus.done),     32'd0);
        chk("mid_rst_data_out", 32'(bus.data_out), 32'h00);
        chk("mid_rst_count",    32'(bus.count),    32'd0);
        chk("mid_rst_Count",    32'(bus.Count),    32'd0);
        sel = 1'b0;
        step(3);
        reset = 1'b1;
        chk("mid_rst_no_done", 32'(n_done), 32'd0);
        step(2);

        // Glitches away from the sample point do not reach data_out
        n_shift = 0;
        send_bits(8'h00, 8, 1'b1);
        chk("glitch00_data",   32'(bus.data_out), 32'h00);
        chk("glitch00_shifts", 32'(n_shift),      32'd8);
        sel = 1'b0; step(2);
        n_shift = 0;
        send_bits(8'hA5, 8, 1'b1);
        chk("glitchA5_data",   32'(bus.data_out), 32'hA5);
        chk("glitchA5_shifts", 32'(n_shift),      32'd8);
        sel = 1'b0; step(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_shift_register

// File: doc/shift_register.md
# shift_register

Receive-side bit sampler and deserializer for the UART RX path. It derives a 16x-oversampling tick (`baud_clk`) from the system clock. While enabled by `sel`, it samples the serial line at mid-bit, shifts eight data bits LSB-first into a byte register, and pulses `done` when the byte is complete. It sits between the RX line synchronizer and the RX control FSM; the FSM drives `sel` (start-bit detected → 1, byte done/stop bit → 0).

## Interface
- `TICK_DIV`, default 651: system clocks per oversample tick (100 MHz / (9600 × 16)); must be ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_in`  in  1  serial RX line, already synchronized to `clk`.
- `sel`  in  1  shift enable; 1 = receiving data bits, 0 = idle/hold.
- `baud_clk`  out  1  oversample tick, one `clk` wide, every `TICK_DIV` clocks.
- `shift_in`  out  1  one-`clk` strobe on the cycle a bit is sampled and shifted.
- `done`  out  1  one-`clk` pulse when the 8th bit is shifted in.
- `data_out`  out  8  received byte, LSB-first assembly.
- `count`  out  5  oversample counter within the current bit, 0..15; bit 4 is always 0.
- `Count`  out  4  number of data bits captured, 0..8.

## Operation
- Tick divider: free-running counter 0..`TICK_DIV`-1 that runs regardless of `sel`. `baud_clk`=1 for the single `clk` cycle in which the divider wraps.
- `sel`=0: `count` and `Count` are cleared to 0 on the next `clk`. `shift_in` and `done` stay 0. `data_out` holds its last value.
- `sel`=1, on each `baud_clk` tick:
  - `count` increments and wraps 15→0.
  - When `count`=7 before the increment (mid-bit) and `Count`<8:
    - `data_out` ← {`data_in`, `data_out[7:1]`}, so the first received bit ends in bit 0 after 8 shifts.
    - `Count` increments.
    - `shift_in` pulses.
  - When that shift makes `Count`=8, `done` pulses in the same cycle.
  - Further ticks with `Count`=8 cause no shifts. `Count` stays 8 until `sel` drops.
- Sampling alignment: `count`=0 corresponds to the tick on which `sel` was first seen high. The FSM asserts `sel` at the start of the first data bit.
- `sel` falling mid-byte aborts the byte: counters clear and `done` does not pulse. `data_out` keeps its partial contents.
- `sel` rising again starts a fresh byte from `count`=0, `Count`=0.

## Timing
- Reset values, all asynchronous: `baud_clk`=0, `shift_in`=0, `done`=0, `data_out`=8'h00, `count`=0, `Count`=0, divider=0.
- First `baud_clk` occurs `TICK_DIV` clocks after reset release.
- Registered outputs; each shift is visible the `clk` after its sampling tick, with `shift_in` and `done` asserted in that same cycle.
- Per bit: 16 ticks = 16×`TICK_DIV` clocks. Byte latency from `sel` rise to `done` is 7 + 7×16 + 1 = 120 ticks.
- `sel` is sampled on every `clk`. A change coincident with a tick takes the new value for that tick.
- Reset asserted mid-byte returns everything to reset values immediately; no `done`.

## Structure
- Shared UART package: `OVERSAMPLE`=16, `MID_SAMPLE`=7, `DATA_BITS`=8, default `TICK_DIV`. The same constants serve the TX side.
- One natural sub-module: `baud_tick_gen` (divider producing `baud_clk`), shared with the UART TX.
- The remainder is a single always_ff block with counters and the shift register.

## Test plan
- Reset/idle, `TICK_DIV`=4, `reset` held low 100 ns then high, `sel`=0:
  - During reset, all outputs are 0.
  - After release, `baud_clk` pulses every 4 clks, one clk wide.
  - `count`, `Count` stay 0 and `done` never fires.
- Byte receive: `sel`=1 aligned to a tick, `data_in` holds bits 1,0,1,0,1,1,0,1 (LSB first) for 16 ticks each.
  - Each bit is sampled at `count`=7, with `shift_in` pulsing 8 times.
  - After the 8th sample, `data_out`=8'hB5 and `done` pulses exactly one clk.
- Line bits 1,1,0,1,0,1,1,0 → `data_out`=8'h6B. Holding `sel`=1 for 2 more bit times gives no further shifts: `Count` stays 8 and `data_out` is unchanged.
- Abort: drop `sel` after 3 bits.
  - Next clk: `count`=0, `Count`=0, no `done`.
  - Re-raise `sel` and send 8'hFF → `data_out`=8'hFF.
- Reset mid-byte: assert `reset`=0 after 5 bits. All outputs clear asynchronously, before the next `clk` edge.
- Glitch rejection: a `data_in` pulse outside the `count`=7 sample point does not alter `data_out`.
